// File: rtl/v3_shift_reg_queue_pkg.sv
// Shared types for the shift-register queue: per-entry shift operation and order-mode constants.
package v3_QueuePkg;

  // FWD takes entry[i-1] (toward the tail), REV takes entry[i+1] (toward the head).
  typedef enum logic [1:0] {
    SHIFT_HOLD,
    SHIFT_WRITE,
    SHIFT_FWD,
    SHIFT_REV
  } shift_op_t;

  localparam int MODE_FIFO = 0;
  localparam int MODE_LIFO = 1;

endpackage

// File: rtl/v3_shift_reg_entry.sv
// One queue slot: a register fed by a 4:1 mux selected by the slot's shift operation.
module v3_shift_reg_entry
  import v3_QueuePkg::*;
#(
  parameter int unsigned p_bitwidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  shift_op_t             op,
  input  logic [p_bitwidth-1:0] wr_data_in,
  input  logic [p_bitwidth-1:0] fwd_in,
  input  logic [p_bitwidth-1:0] rev_in,
  output logic [p_bitwidth-1:0] data_out
);

  logic [p_bitwidth-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else begin
      case (op)
        SHIFT_WRITE: data_q <= wr_data_in;
        SHIFT_FWD:   data_q <= fwd_in;
        SHIFT_REV:   data_q <= rev_in;
        default:     data_q <= data_q;
      endcase
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/v3_shift_reg_queue.sv
// Shift-register queue with val/rdy handshakes, flush and random-access peek.
// Entry 0 is always the head; FIFO or LIFO order is fixed by p_mode.
module v3_shift_reg_queue
  import v3_QueuePkg::*;
#(
  parameter int unsigned p_depth    = 8,
  parameter int unsigned p_bitwidth = 32,
  parameter int unsigned p_mode     = 0,
  parameter int unsigned p_cntwidth = $clog2(p_depth + 1),
  parameter int unsigned p_idwidth  = $clog2(p_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  enq_val,
  output logic                  enq_rdy,
  input  logic [p_bitwidth-1:0] enq_data,
  output logic                  deq_val,
  input  logic                  deq_rdy,
  output logic [p_bitwidth-1:0] deq_data,
  input  logic [p_idwidth-1:0]  peek_idx,
  output logic [p_bitwidth-1:0] peek_data,
  output logic [p_cntwidth-1:0] count
);

  if (p_mode != MODE_FIFO && p_mode != MODE_LIFO) begin : g_bad_mode
    $error("v3_shift_reg_queue: p_mode must be 0 (FIFO) or 1 (LIFO)");
  end

  localparam logic [p_cntwidth-1:0] One  = p_cntwidth'(1);
  localparam logic [p_cntwidth-1:0] Full = p_cntwidth'(p_depth);

  logic [p_bitwidth-1:0] entry_q [p_depth];
  logic [p_bitwidth-1:0] fwd_nb  [p_depth];
  logic [p_bitwidth-1:0] rev_nb  [p_depth];
  shift_op_t             op      [p_depth];
  logic                  clr     [p_depth];
  logic [p_cntwidth-1:0] count_q, count_d;
  logic                  enq_fire, deq_fire;

  assign enq_rdy  = (count_q != Full);
  assign deq_val  = (count_q != '0);
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;
  assign deq_data = entry_q[0];
  assign count    = count_q;

  always_comb begin
    logic [p_cntwidth-1:0] idx;
    idx = '0;
    for (int i = 0; i < p_depth; i++) begin
      op[i]  = SHIFT_HOLD;
      clr[i] = flush;
      idx    = p_cntwidth'(i);
      if (!flush) begin
        if (p_mode == MODE_LIFO && enq_fire && deq_fire) begin
          // New item replaces the outgoing head in place; nothing moves.
          if (i == 0) op[i] = SHIFT_WRITE;
        end else if (deq_fire) begin
          if (idx + One < count_q) begin
            op[i] = SHIFT_REV;
          end else if (idx + One == count_q) begin
            if (enq_fire) op[i] = SHIFT_WRITE;
            else          clr[i] = 1'b1;
          end
        end else if (enq_fire) begin
          if (p_mode == MODE_FIFO) begin
            if (idx == count_q) op[i] = SHIFT_WRITE;
          end else begin
            if (i == 0)              op[i] = SHIFT_WRITE;
            else if (idx <= count_q) op[i] = SHIFT_FWD;
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush)                      count_d = '0;
    else if (enq_fire && !deq_fire) count_d = count_q + One;
    else if (deq_fire && !enq_fire) count_d = count_q - One;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  for (genvar g = 0; g < p_depth; g++) begin : g_entry
    if (g == 0) begin : g_first
      assign fwd_nb[g] = '0;
    end else begin : g_mid_fwd
      assign fwd_nb[g] = entry_q[g-1];
    end
    if (g == p_depth - 1) begin : g_last
      assign rev_nb[g] = '0;
    end else begin : g_mid_rev
      assign rev_nb[g] = entry_q[g+1];
    end

    v3_shift_reg_entry #(
      .p_bitwidth(p_bitwidth)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .clear     (clr[g]),
      .op        (op[g]),
      .wr_data_in(enq_data),
      .fwd_in    (fwd_nb[g]),
      .rev_in    (rev_nb[g]),
      .data_out  (entry_q[g])
    );
  end

  // Entries at or beyond count are zero already; the guard also covers indices past p_depth.
  always_comb begin
    peek_data = '0;
    if (p_cntwidth'(peek_idx) < count_q) peek_data = entry_q[peek_idx];
  end

endmodule

// File: tb/tb_v3_shift_reg_queue.sv
// Bench for v3_shift_reg_queue: a FIFO and a LIFO instance share stimulus, each checked
// against a queue-based model of its ordering rules.
module tb_v3_shift_reg_queue;

  localparam int D  = 4;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, enq_val, deq_rdy;
  logic [W-1:0]  enq_data;
  logic [IW-1:0] peek_idx;

  logic          f_enq_rdy, f_deq_val, l_enq_rdy, l_deq_val;
  logic [W-1:0]  f_deq_data, f_peek_data, l_deq_data, l_peek_data;
  logic [CW-1:0] f_count, l_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] lq[$];

  always #5 clk = ~clk;

  v3_shift_reg_queue #(.p_depth(D), .p_bitwidth(W), .p_mode(0)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .enq_val(enq_val), .enq_rdy(f_enq_rdy),
    .enq_data(enq_data), .deq_val(f_deq_val), .deq_rdy(deq_rdy), .deq_data(f_deq_data),
    .peek_idx(peek_idx), .peek_data(f_peek_data), .count(f_count)
  );

  v3_shift_reg_queue #(.p_depth(D), .p_bitwidth(W), .p_mode(1)) u_lifo (
    .clk(clk), .rst(rst), .flush(flush), .enq_val(enq_val), .enq_rdy(l_enq_rdy),
    .enq_data(enq_data), .deq_val(l_deq_val), .deq_rdy(deq_rdy), .deq_data(l_deq_data),
    .peek_idx(peek_idx), .peek_data(l_peek_data), .count(l_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] qat(input logic [W-1:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : '0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " fifo.count"},     32'(f_count),     32'(fq.size()));
    chk({tag, " fifo.enq_rdy"},   32'(f_enq_rdy),   32'(fq.size() != D));
    chk({tag, " fifo.deq_val"},   32'(f_deq_val),   32'(fq.size() != 0));
    chk({tag, " fifo.deq_data"},  32'(f_deq_data),  32'(qat(fq, 0)));
    chk({tag, " fifo.peek_data"}, 32'(f_peek_data), 32'(qat(fq, int'(peek_idx))));
    chk({tag, " lifo.count"},     32'(l_count),     32'(lq.size()));
    chk({tag, " lifo.enq_rdy"},   32'(l_enq_rdy),   32'(lq.size() != D));
    chk({tag, " lifo.deq_val"},   32'(l_deq_val),   32'(lq.size() != 0));
    chk({tag, " lifo.deq_data"},  32'(l_deq_data),  32'(qat(lq, 0)));
    chk({tag, " lifo.peek_data"}, 32'(l_peek_data), 32'(qat(lq, int'(peek_idx))));
  endtask

  task automatic drive(input logic ev, input logic [W-1:0] ed, input logic dr, input logic fl,
                       input logic [IW-1:0] pi);
    enq_val  = ev;
    enq_data = ed;
    deq_rdy  = dr;
    flush    = fl;
    peek_idx = pi;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  // Apply the queue rules to both models at the edge, then leave the edge behind.
  task automatic tick();
    bit fe, fd, le, ld;
    @(posedge clk);
    fe = enq_val && fq.size() < D;
    fd = deq_rdy && fq.size() > 0;
    le = enq_val && lq.size() < D;
    ld = deq_rdy && lq.size() > 0;
    if (flush) begin
      fq.delete();
      lq.delete();
    end else begin
      if (fd) void'(fq.pop_front());
      if (fe) fq.push_back(enq_data);
      if (ld) void'(lq.pop_front());
      if (le) lq.push_front(enq_data);
    end
    #1;
  endtask

  task automatic step(input string tag, input logic ev, input logic [W-1:0] ed, input logic dr,
                      input logic fl, input logic [IW-1:0] pi);
    drive(ev, ed, dr, fl, pi);
    settle(tag);
    tick();
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");

    // Async reset mid-cycle with data present.
    step("pre_rst", 1'b1, 8'h11, 1'b0, 1'b0, 2'd0);
    step("pre_rst", 1'b1, 8'h22, 1'b0, 1'b0, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    fq.delete();
    lq.delete();
    chk("async_rst fifo.count",   32'(f_count),     32'd0);
    chk("async_rst fifo.enq_rdy", 32'(f_enq_rdy),   32'd1);
    chk("async_rst fifo.deq_val", 32'(f_deq_val),   32'd0);
    chk("async_rst fifo.peek",    32'(f_peek_data), 32'd0);
    chk("async_rst lifo.count",   32'(l_count),     32'd0);
    chk("async_rst lifo.deq",     32'(l_deq_data),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 8'hFF, 1'b0, 1'b0, IW'(i));

    // FIFO fill, overflow attempt, drain.
    step("fill", 1'b1, 8'h0A, 1'b0, 1'b0, 2'd0);
    step("fill", 1'b1, 8'h0B, 1'b0, 1'b0, 2'd0);
    step("fill", 1'b1, 8'h0C, 1'b0, 1'b0, 2'd1);
    step("fill", 1'b1, 8'h0D, 1'b0, 1'b0, 2'd2);
    step("full_enq", 1'b1, 8'h0F, 1'b0, 1'b0, 2'd3);
    chk("full fifo.count", 32'(f_count), 32'd4);
    chk("full fifo.enq_rdy", 32'(f_enq_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] exp_f;
      exp_f = W'(8'h0A + i);
      drive(1'b0, '0, 1'b1, 1'b0, 2'd0);
      settle("drain");
      chk("drain fifo.order", 32'(f_deq_data), 32'(exp_f));
      tick();
    end
    chk("drained fifo.count", 32'(f_count), 32'd0);

    // Simultaneous enq+deq on a partial FIFO.
    step("sim", 1'b1, 8'h0A, 1'b0, 1'b0, 2'd0);
    step("sim", 1'b1, 8'h0B, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'h0E, 1'b1, 1'b0, 2'd1);
    settle("sim_both");
    chk("sim fifo.deq_data", 32'(f_deq_data), 32'h0A);
    tick();
    step("sim_after", 1'b0, '0, 1'b0, 1'b0, 2'd1);
    chk("sim fifo.head", 32'(f_deq_data), 32'h0B);
    chk("sim fifo.tail", 32'(f_peek_data), 32'h0E);

    // Enq+deq while full: only the deq fires.
    step("flush", 1'b0, '0, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) step("refill", 1'b1, W'(8'h30 + i), 1'b0, 1'b0, 2'd0);
    step("full_both", 1'b1, 8'h77, 1'b1, 1'b0, 2'd0);
    step("full_both_after", 1'b0, '0, 1'b0, 1'b0, 2'd3);
    chk("full_both fifo.count", 32'(f_count), 32'd3);
    chk("full_both fifo.enq_rdy", 32'(f_enq_rdy), 32'd1);

    // LIFO ordering and replace-head.
    step("flush", 1'b0, '0, 1'b0, 1'b1, 2'd0);
    for (int i = 1; i <= 3; i++) step("lifo_fill", 1'b1, W'(i), 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] exp_l;
      exp_l = W'(3 - i);
      drive(1'b0, '0, 1'b0, 1'b0, IW'(i));
      settle("lifo_peek");
      chk("lifo.peek_order", 32'(l_peek_data), 32'(exp_l));
      tick();
    end
    drive(1'b1, 8'h09, 1'b1, 1'b0, 2'd0);
    settle("lifo_both");
    chk("lifo_both lifo.deq_data", 32'(l_deq_data), 32'h03);
    tick();
    step("lifo_after", 1'b0, '0, 1'b0, 1'b0, 2'd1);
    chk("lifo_after lifo.head", 32'(l_deq_data), 32'h09);
    chk("lifo_after lifo.count", 32'(l_count), 32'd3);

    // Flush beats a simultaneous enq.
    step("flush_enq", 1'b1, 8'h07, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) step("post_flush", 1'b0, '0, 1'b0, 1'b0, IW'(i));
    chk("post_flush fifo.deq_val", 32'(f_deq_val), 32'd0);
    step("enq5", 1'b1, 8'h05, 1'b0, 1'b0, 2'd0);
    step("enq5_after", 1'b0, '0, 1'b0, 1'b0, 2'd0);
    chk("enq5 fifo.head", 32'(f_deq_data), 32'h05);
    chk("enq5 lifo.head", 32'(l_deq_data), 32'h05);

    // Peek bounds at count 2.
    step("pb", 1'b1, 8'h06, 1'b0, 1'b0, 2'd0);
    step("pb_oob", 1'b0, '0, 1'b0, 1'b0, 2'd3);
    step("pb_in", 1'b0, '0, 1'b0, 1'b0, 2'd1);

    // Randomized traffic against the models.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), IW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
